aux_island_sched: RTL and testbench

//  Receive-side scheduler for the audio/aux FIFO (25b words {pos[15:0],aux[8:0]}).

---
 rtl/aux_pkg.sv | 20 ++
 rtl/line_pos_cnt.sv | 21 ++
 rtl/aux_island_sched.sv | 204 ++++++++++++++++++++
 tb/tb_aux_island_sched.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/aux_pkg.sv
// Shared definitions for the aux island scheduler: FSM encoding and the
// {pos, aux} FIFO word layout.
package aux_pkg;

  typedef enum logic [2:0] {
    FIRST = 3'd0,
    PRIME = 3'd1,
    IDLE  = 3'd2,
    BURST = 3'd3,
    DRAIN = 3'd4
  } sched_state_t;

  localparam int POS_W_DEF  = 16;
  localparam int AUX_W_DEF  = 9;
  localparam int AUX_WORD_W = POS_W_DEF + AUX_W_DEF;
  localparam int POS_MSB    = AUX_WORD_W - 1;
  localparam int POS_LSB    = AUX_W_DEF;
  localparam int AUX_MSB    = AUX_W_DEF - 1;

endpackage

// File: rtl/line_pos_cnt.sv
// Pixel position since the end of active video: cleared while vde is high,
// counts once per clock otherwise and holds at all-ones instead of wrapping.
module line_pos_cnt #(
  parameter int W = 16
) (
  input  logic         fifo_clk,
  input  logic         sys_rst,
  input  logic         vde,
  output logic [W-1:0] pos
);

  always_ff @(posedge fifo_clk or posedge sys_rst) begin
    if (sys_rst)
      pos <= '0;
    else if (vde)
      pos <= '0;
    else if (pos != {W{1'b1}})
      pos <= pos + 1'b1;
  end

endmodule

// File: rtl/aux_island_sched.sv
// Replays timestamped aux FIFO words as ISLAND_LEN-word data islands with a
// regenerated ade. Define AUX_SCHED_STATS_EN to add drop_cnt/abort_cnt outputs.
module aux_island_sched
  import aux_pkg::*;
#(
  parameter int ISLAND_LEN = 32,
  parameter int POS_W      = POS_MSB - POS_LSB + 1,
  parameter int AUX_W      = AUX_MSB + 1
) (
  input  logic                   fifo_clk,
  input  logic                   sys_rst,
  input  logic                   vde,
  input  logic                   ax_empty,
  input  logic [POS_W+AUX_W-1:0] ax_dout,
  output logic                   ax_rd_en,
  output logic                   ade,
  output logic [AUX_W-1:0]       aux_out,
  output logic                   underflow,
  output logic [2:0]             state_o
`ifdef AUX_SCHED_STATS_EN
  ,
  output logic [15:0]            drop_cnt,
  output logic [15:0]            abort_cnt
`endif
);

  localparam logic [5:0] LAST = 6'(ISLAND_LEN - 1);
  localparam logic [5:0] PREF = 6'(ISLAND_LEN - 2);

  sched_state_t     state;
  logic [POS_W-1:0] txpos;
  logic [POS_W:0]   txpos_nx;
  logic             txpos_sat;
  logic [POS_W-1:0] dout_pos;
  logic [AUX_W-1:0] dout_aux;
  logic [POS_W-1:0] head_pos;
  logic [AUX_W-1:0] head_aux;
  logic             head_vld;
  logic [5:0]       cnt;
  logic [5:0]       drain_left;
  logic             rd_q;
  logic [AUX_W-1:0] dq_aux;
  logic             rd_want;
  logic             rd_req;
  logic             hit;
  logic             stale;
  logic             cont;

  line_pos_cnt #(.W(POS_W)) u_pos (
    .fifo_clk (fifo_clk),
    .sys_rst  (sys_rst),
    .vde      (vde),
    .pos      (txpos)
  );

  assign txpos_nx  = {1'b0, txpos} + 1'b1;
  assign txpos_sat = &txpos;
  assign dout_pos  = ax_dout[POS_W+AUX_W-1:AUX_W];
  assign dout_aux  = ax_dout[AUX_W-1:0];
  assign state_o   = state;

  // Read handshake: ax_rd_en is only raised while !ax_empty; the FIFO presents
  // the word on ax_dout during the following cycle, flagged here by rd_q.
  // rd_req marks reads the burst cannot do without (their absence is underflow).
  always_comb begin
    rd_want = 1'b0;
    rd_req  = 1'b0;
    hit     = head_vld && !vde && (txpos_nx == {1'b0, head_pos});
    stale   = head_vld && !vde && !txpos_sat && (head_pos <= txpos);
    cont    = rd_q && ({1'b0, dout_pos} == txpos_nx);
    case (state)
      PRIME: rd_want = !rd_q && !vde;
      IDLE: begin
        if (hit) begin
          rd_want = 1'b1;
          rd_req  = 1'b1;
        end else if (stale) begin
          rd_want = 1'b1;
        end else if (!head_vld && !rd_q) begin
          rd_want = 1'b1;
        end
      end
      BURST: begin
        if (vde) begin
          rd_want = 1'b0;
        end else if (cnt < PREF) begin
          rd_want = 1'b1;
          rd_req  = 1'b1;
        end else if (cnt == PREF) begin
          rd_want = 1'b1;
        end else if (cont) begin
          rd_want = 1'b1;
          rd_req  = 1'b1;
        end
      end
      DRAIN: rd_want = (drain_left != 6'd0);
      default: rd_want = 1'b0;
    endcase
  end

  assign ax_rd_en = rd_want && !ax_empty;

  always_ff @(posedge fifo_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state      <= FIRST;
      head_pos   <= '0;
      head_aux   <= '0;
      head_vld   <= 1'b0;
      cnt        <= '0;
      drain_left <= '0;
      rd_q       <= 1'b0;
      dq_aux     <= '0;
      ade        <= 1'b0;
      aux_out    <= '0;
      underflow  <= 1'b0;
    end else begin
      rd_q    <= ax_rd_en;
      dq_aux  <= rd_q ? dout_aux : '0;
      ade     <= 1'b0;
      aux_out <= '0;
      if (rd_req && ax_empty)
        underflow <= 1'b1;
      case (state)
        FIRST: if (vde) state <= PRIME;
        PRIME: begin
          if (rd_q) begin
            head_pos <= dout_pos;
            head_aux <= dout_aux;
            head_vld <= 1'b1;
            state    <= IDLE;
          end
        end
        IDLE: begin
          if (hit) begin
            head_vld <= 1'b0;
            cnt      <= '0;
            state    <= BURST;
          end else if (stale) begin
            head_vld <= 1'b0;
          end else if (rd_q) begin
            head_pos <= dout_pos;
            head_aux <= dout_aux;
            head_vld <= 1'b1;
          end
        end
        BURST: begin
          if (vde) begin
            // The last word already holds the prefetched head, so nothing to drain.
            if (cnt == LAST) begin
              head_pos <= dout_pos;
              head_aux <= dout_aux;
              head_vld <= rd_q;
              state    <= IDLE;
            end else begin
              drain_left <= LAST - cnt;
              state      <= DRAIN;
            end
          end else begin
            ade     <= 1'b1;
            aux_out <= (cnt == 6'd0) ? head_aux : dq_aux;
            if (cnt != LAST) begin
              cnt <= cnt + 6'd1;
            end else if (cont) begin
              cnt      <= '0;
              head_pos <= dout_pos;
              head_aux <= dout_aux;
            end else begin
              head_pos <= dout_pos;
              head_aux <= dout_aux;
              head_vld <= rd_q;
              state    <= IDLE;
            end
          end
        end
        DRAIN: begin
          if (ax_rd_en) begin
            drain_left <= drain_left - 6'd1;
          end else if (drain_left == 6'd0 && rd_q) begin
            head_pos <= dout_pos;
            head_aux <= dout_aux;
            head_vld <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= FIRST;
      endcase
    end
  end

`ifdef AUX_SCHED_STATS_EN
  always_ff @(posedge fifo_clk or posedge sys_rst) begin
    if (sys_rst) begin
      drop_cnt  <= '0;
      abort_cnt <= '0;
    end else begin
      if (state == IDLE && !hit && stale && drop_cnt != 16'hFFFF)
        drop_cnt <= drop_cnt + 16'd1;
      if (state == BURST && vde && abort_cnt != 16'hFFFF)
        abort_cnt <= abort_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_aux_island_sched.sv
// Directed bench for aux_island_sched with a behavioural aux FIFO and
// hand-computed burst positions, lengths and payloads.
module tb_aux_island_sched;
  import aux_pkg::*;

  logic                  fifo_clk = 1'b0;
  logic                  sys_rst;
  logic                  vde;
  logic                  ax_empty;
  logic [AUX_WORD_W-1:0] ax_dout;
  logic                  ax_rd_en;
  logic                  ade;
  logic [AUX_MSB:0]      aux_out;
  logic                  underflow;
  logic [2:0]            state_o;
`ifdef AUX_SCHED_STATS_EN
  logic [15:0]           drop_cnt;
  logic [15:0]           abort_cnt;
`endif

  aux_island_sched dut (
    .fifo_clk  (fifo_clk),
    .sys_rst   (sys_rst),
    .vde       (vde),
    .ax_empty  (ax_empty),
    .ax_dout   (ax_dout),
    .ax_rd_en  (ax_rd_en),
    .ade       (ade),
    .aux_out   (aux_out),
    .underflow (underflow),
    .state_o   (state_o)
`ifdef AUX_SCHED_STATS_EN
    ,
    .drop_cnt  (drop_cnt),
    .abort_cnt (abort_cnt)
`endif
  );

  always #5 fifo_clk = ~fifo_clk;

  logic [AUX_WORD_W-1:0] fifo_q[$];
  logic [AUX_MSB:0]      aux_log[$];
  int                    rise_pos[$];
  int n_run = 0;
  int n_fail = 0;
  int n_reads, rd_bad, ade_len, ade_rises, aux_leak, tb_pos;
  logic ade_prev, rd_pend;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [AUX_MSB:0] aux_of(input int s, input int i);
    return 9'(s * 64 + i + 1);
  endfunction

  task automatic push_burst(input int pos, input int n, input int s);
    logic [AUX_WORD_W-1:0] w;
    for (int i = 0; i < n; i++) begin
      w = '0;
      w[POS_MSB:POS_LSB] = 16'(pos);
      w[AUX_MSB:0] = aux_of(s, i);
      fifo_q.push_back(w);
    end
    ax_empty = (fifo_q.size() == 0);
  endtask

  // One clock: monitor at negedge, FIFO model updates just after posedge.
  task automatic tick();
    @(negedge fifo_clk);
    rd_pend = ax_rd_en;
    if (ax_rd_en) begin
      n_reads++;
      if (ax_empty) rd_bad++;
    end
    if (ade) begin
      if (!ade_prev) begin
        ade_rises++;
        rise_pos.push_back(tb_pos);
      end
      ade_len++;
      aux_log.push_back(aux_out);
    end else if (aux_out != '0) begin
      aux_leak++;
    end
    ade_prev = ade;
    @(posedge fifo_clk);
    if (sys_rst || vde) tb_pos = 0;
    else if (tb_pos != 65535) tb_pos = tb_pos + 1;
    #1;
    if (rd_pend && fifo_q.size() > 0) ax_dout = fifo_q.pop_front();
    ax_empty = (fifo_q.size() == 0);
  endtask

  task automatic run(input logic v, input int n);
    vde = v;
    repeat (n) tick();
  endtask

  task automatic clear_mon();
    n_reads = 0; rd_bad = 0; ade_len = 0; ade_rises = 0; aux_leak = 0;
    ade_prev = 1'b0;
    aux_log.delete();
    rise_pos.delete();
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    vde = 1'b0;
    fifo_q.delete();
    ax_empty = 1'b1;
    ax_dout = '0;
    tb_pos = 0;
    tick();
    tick();
    sys_rst = 1'b0;
    clear_mon();
  endtask

  initial begin
    sys_rst = 1'b0;
    vde = 1'b0;
    ax_empty = 1'b1;
    ax_dout = '0;
    clear_mon();
    do_reset();

    // 1: single burst at pos 100 over three lines
    check("rst_ade", 32'(ade), 0);
    check("rst_rd_en", 32'(ax_rd_en), 0);
    check("rst_aux", 32'(aux_out), 0);
    check("rst_underflow", 32'(underflow), 0);
    check("rst_state", 32'(state_o), 0);
    push_burst(100, 32, 0);
    run(1, 20); run(0, 300);
    run(1, 20); run(0, 50);
    run(1, 20); run(0, 50);
    check("t1_rises", ade_rises, 1);
    check("t1_rise_pos", rise_pos[0], 101);
    check("t1_ade_len", ade_len, 32);
    for (int i = 0; i < 32; i++) check($sformatf("t1_aux%0d", i), 32'(aux_log[i]), 32'(aux_of(0, i)));
    check("t1_reads", n_reads, 32);
    check("t1_underflow", 32'(underflow), 0);
    check("t1_rd_bad", rd_bad, 0);
    check("t1_aux_leak", aux_leak, 0);
    check("t1_state", 32'(state_o), 2);

    // 2: back-to-back bursts at 100 and 132
    do_reset();
    push_burst(100, 32, 1);
    push_burst(132, 32, 2);
    run(1, 20); run(0, 300);
    check("t2_rises", ade_rises, 1);
    check("t2_rise_pos", rise_pos[0], 101);
    check("t2_ade_len", ade_len, 64);
    check("t2_aux0", 32'(aux_log[0]), 32'(aux_of(1, 0)));
    check("t2_aux31", 32'(aux_log[31]), 32'(aux_of(1, 31)));
    check("t2_aux32", 32'(aux_log[32]), 32'(aux_of(2, 0)));
    check("t2_aux63", 32'(aux_log[63]), 32'(aux_of(2, 31)));
    check("t2_reads", n_reads, 64);
    check("t2_underflow", 32'(underflow), 0);

    // 3: stale head pos 5 arrives after txpos 131, dropped; pos 200 plays at 201
    do_reset();
    push_burst(100, 32, 0);
    push_burst(5, 1, 3);
    push_burst(200, 32, 2);
    run(1, 20); run(0, 300);
    check("t3_rises", ade_rises, 2);
    check("t3_rise_pos", rise_pos[1], 201);
    check("t3_ade_len", ade_len, 64);
    check("t3_aux32", 32'(aux_log[32]), 32'(aux_of(2, 0)));
    check("t3_reads", n_reads, 65);
    check("t3_underflow", 32'(underflow), 0);
`ifdef AUX_SCHED_STATS_EN
    check("t3_drop_cnt", 32'(drop_cnt), 1);
`endif

    // 4: only 20 words for a 32-word island
    do_reset();
    push_burst(100, 20, 1);
    run(1, 20); run(0, 300);
    check("t4_rises", ade_rises, 1);
    check("t4_ade_len", ade_len, 32);
    check("t4_aux19", 32'(aux_log[19]), 32'(aux_of(1, 19)));
    check("t4_aux20", 32'(aux_log[20]), 0);
    check("t4_aux31", 32'(aux_log[31]), 0);
    check("t4_underflow", 32'(underflow), 1);
    check("t4_rd_bad", rd_bad, 0);
    check("t4_reads", n_reads, 20);

    // 5: vde returns while the burst is on its 10th word (txpos 109)
    do_reset();
    push_burst(100, 32, 0);
    push_burst(50, 32, 1);
    run(1, 20); run(0, 109);
    run(1, 5);
    check("t5_state_drain", 32'(state_o), 4);
    run(1, 35);
    check("t5_ade_len_abort", ade_len, 9);
    check("t5_aux8", 32'(aux_log[8]), 32'(aux_of(0, 8)));
    check("t5_reads_drain", n_reads, 33);
    check("t5_state_idle", 32'(state_o), 2);
`ifdef AUX_SCHED_STATS_EN
    check("t5_abort_cnt", 32'(abort_cnt), 1);
`endif
    run(0, 150);
    check("t5_rises", ade_rises, 2);
    check("t5_rise_pos", rise_pos[1], 51);
    check("t5_ade_len", ade_len, 41);
    check("t5_aux9", 32'(aux_log[9]), 32'(aux_of(1, 0)));
    check("t5_aux40", 32'(aux_log[40]), 32'(aux_of(1, 31)));
    check("t5_reads", n_reads, 64);
    check("t5_underflow", 32'(underflow), 0);

    // 6: asynchronous reset in the middle of a burst, then recovery
    do_reset();
    push_burst(100, 32, 0);
    run(1, 20); run(0, 106);
    check("t6_ade_before", 32'(ade), 1);
    #2;
    sys_rst = 1'b1;
    #1;
    check("t6_ade_async", 32'(ade), 0);
    check("t6_rd_en_async", 32'(ax_rd_en), 0);
    check("t6_state_async", 32'(state_o), 0);
    check("t6_aux_async", 32'(aux_out), 0);
    fifo_q.delete();
    ax_empty = 1'b1;
    tick();
    sys_rst = 1'b0;
    clear_mon();
    push_burst(80, 32, 2);
    run(1, 20); run(0, 200);
    check("t6_rises", ade_rises, 1);
    check("t6_rise_pos", rise_pos[0], 81);
    check("t6_ade_len", ade_len, 32);
    check("t6_aux0", 32'(aux_log[0]), 32'(aux_of(2, 0)));
    check("t6_aux31", 32'(aux_log[31]), 32'(aux_of(2, 31)));
    check("t6_reads", n_reads, 32);
    check("t6_underflow", 32'(underflow), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
